// File: rtl/echo_pkg.sv
// Shared definitions for the echo request/indication message path.
// Message layout (96 bits): [95:64] tag, [63:32] meth, [31:0] v.
// No ports; imported by echo_msg_fifo and echo_request_responder.
package echo_pkg;

    localparam int unsigned ECHO_MSG_W = 96;
    localparam int unsigned TAG_W      = 32;
    localparam int unsigned FIELD_W    = 32;

    localparam int unsigned TAG_LSB  = 64;
    localparam int unsigned METH_LSB = 32;
    localparam int unsigned V_LSB    = 0;

    localparam logic [TAG_W-1:0] ECHO_TAG_SAY   = 32'd0;
    localparam logic [TAG_W-1:0] ECHO_TAG_HEARD = 32'd0;

    typedef struct packed {
        logic [FIELD_W-1:0] meth;
        logic [FIELD_W-1:0] v;
    } echo_payload_t;

    // Build an outgoing heard indication from a buffered payload.
    function automatic logic [ECHO_MSG_W-1:0] pack_heard(input echo_payload_t p);
        return {ECHO_TAG_HEARD, p.meth, p.v};
    endfunction

endpackage

// File: rtl/echo_msg_fifo.sv
// DEPTH-entry payload FIFO, no bypass. Head entry is presented combinationally.
// Ports:
//   CLK, nRST  clock and asynchronous active-high reset
//   push/wdata write one payload (caller guarantees not full)
//   pop        drop the head entry (caller guarantees not empty)
//   rdata      head payload
//   count      entries held (0..DEPTH)
//   empty      count == 0
module echo_msg_fifo
    import echo_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       push,
    input  echo_payload_t              wdata,
    input  logic                       pop,
    output echo_payload_t              rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    echo_payload_t    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_q;

    // Storage array carries no reset; validity is tracked by the count.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign count = cnt_q;
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/echo_request_responder.sv
// Far-end echo responder: decodes say(meth, v) requests, buffers payloads and
// returns each one, in order, as a heard(meth, v) indication.
// Optional feature: define ECHO_RESPONDER_ERRCNT_EN to build the saturating
// dropped-message counter; otherwise err_count is tied to 0.
// Ports:
//   CLK, nRST                  clock, asynchronous active-high reset
//   req_enq_ena/_v/_rdy        request input handshake (96-bit message)
//   ind_enq_ena/_v/_rdy        indication output handshake (96-bit message)
//   occupancy                  payloads held including the output register
//   err_count                  non-say messages dropped, saturating
module echo_request_responder
    import echo_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ERR_W = 8
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      req_enq_ena,
    input  logic [ECHO_MSG_W-1:0]     req_enq_v,
    output logic                      req_enq_rdy,
    output logic                      ind_enq_ena,
    output logic [ECHO_MSG_W-1:0]     ind_enq_v,
    input  logic                      ind_enq_rdy,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic [ERR_W-1:0]          err_count
);

    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    echo_payload_t    in_payload;
    logic [TAG_W-1:0] in_tag;
    logic             accept;
    logic             is_say;
    logic             send;
    logic             slot_free;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic [OCC_W-1:0] fifo_count;
    echo_payload_t    fifo_head;
    logic [OCC_W-1:0] occ;

    logic             out_valid;
    echo_payload_t    out_data;

    // Request decode.
    assign in_tag          = req_enq_v[TAG_LSB +: TAG_W];
    assign in_payload.meth = req_enq_v[METH_LSB +: FIELD_W];
    assign in_payload.v    = req_enq_v[V_LSB +: FIELD_W];

    // Ready depends on registered occupancy only, never on ind_enq_rdy.
    assign occ          = fifo_count + OCC_W'(out_valid);
    assign req_enq_rdy  = (occ != OCC_W'(DEPTH + 1));
    assign accept       = req_enq_ena && req_enq_rdy;
    assign is_say       = accept && (in_tag == ECHO_TAG_SAY);

    // Output register can take a new payload when idle or when sending now.
    assign send      = out_valid && ind_enq_rdy;
    assign slot_free = !out_valid || send;
    assign fifo_pop  = slot_free && !fifo_empty;
    // A say bypasses the FIFO only when the FIFO is empty and the slot frees.
    assign fifo_push = is_say && !(slot_free && fifo_empty);

    echo_msg_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .nRST  (nRST),
        .push  (fifo_push),
        .wdata (in_payload),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    // Output register: refill from FIFO head first, else from a bypassed say.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (slot_free) begin
            if (!fifo_empty) begin
                out_valid <= 1'b1;
                out_data  <= fifo_head;
            end else if (is_say) begin
                out_valid <= 1'b1;
                out_data  <= in_payload;
            end else begin
                out_valid <= 1'b0;
                out_data  <= '0;
            end
        end
    end

    assign ind_enq_ena = out_valid;
    assign ind_enq_v   = out_valid ? pack_heard(out_data) : '0;
    assign occupancy   = occ;

`ifdef ECHO_RESPONDER_ERRCNT_EN
    logic [ERR_W-1:0] err_q;

    // Counts accepted non-say messages, holding at all-ones.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            err_q <= '0;
        end else if (accept && !is_say && (err_q != '1)) begin
            err_q <= err_q + ERR_W'(1);
        end
    end

    assign err_count = err_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_echo_request_responder.sv
// Self-checking bench for echo_request_responder: directed scenarios plus
// randomized traffic compared every cycle against a queue-based model.
module tb_echo_request_responder;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ERR_W  = 8;
    localparam int unsigned ERR_W2 = 2;
    localparam int unsigned OCC_W  = $clog2(DEPTH) + 1;
`ifdef ECHO_RESPONDER_ERRCNT_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              req_ena;
    logic [95:0]       req_v;
    logic              req_rdy;
    logic              ind_ena;
    logic [95:0]       ind_v;
    logic              ind_rdy;
    logic [OCC_W-1:0]  occ;
    logic [ERR_W-1:0]  err;

    logic              req_rdy2;
    logic              ind_ena2;
    logic [95:0]       ind_v2;
    logic [OCC_W-1:0]  occ2;
    logic [ERR_W2-1:0] err2;

    int n_pass  = 0;
    int n_total = 0;

    echo_request_responder #(.DEPTH(DEPTH), .ERR_W(ERR_W)) u_dut (
        .CLK         (clk),
        .nRST        (rst),
        .req_enq_ena (req_ena),
        .req_enq_v   (req_v),
        .req_enq_rdy (req_rdy),
        .ind_enq_ena (ind_ena),
        .ind_enq_v   (ind_v),
        .ind_enq_rdy (ind_rdy),
        .occupancy   (occ),
        .err_count   (err)
    );

    // Second instance with a 2-bit counter to observe saturation.
    echo_request_responder #(.DEPTH(DEPTH), .ERR_W(ERR_W2)) u_dut2 (
        .CLK         (clk),
        .nRST        (rst),
        .req_enq_ena (req_ena),
        .req_enq_v   (req_v),
        .req_enq_rdy (req_rdy2),
        .ind_enq_ena (ind_ena2),
        .ind_enq_v   (ind_v2),
        .ind_enq_rdy (ind_rdy),
        .occupancy   (occ2),
        .err_count   (err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] q[$];
    int          err_m1;
    int          err_m2;
    int          rst_epoch = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            err_m1 = 0;
            err_m2 = 0;
            rst_epoch++;
        end else begin
            automatic int  s      = q.size();
            automatic bit  acc    = req_ena && (s < DEPTH + 1);
            automatic bit  snd    = (s > 0) && ind_rdy;
            if (snd) void'(q.pop_front());
            if (acc) begin
                if (req_v[95:64] == 32'd0) begin
                    q.push_back(req_v[63:0]);
                end else begin
                    if (err_m1 < 255) err_m1++;
                    if (err_m2 < 3)   err_m2++;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit          streaming = 1'b0;
    int          max_occ   = 0;
    bit          prev_stall = 1'b0;
    logic [95:0] prev_v;
    int          prev_epoch = 0;

    always @(negedge clk) begin
        if (!rst) begin
            automatic logic [95:0] exp_v = (q.size() > 0) ? {32'd0, q[0]} : 96'd0;
            chk("ena", 96'(ind_ena), 96'(q.size() > 0));
            chk("ind_v", ind_v, exp_v);
            chk("occupancy", 96'(occ), 96'(q.size()));
            chk("req_rdy", 96'(req_rdy), 96'(q.size() < DEPTH + 1));
            chk("err_count", 96'(err), ERR_ON ? 96'(err_m1) : 96'd0);
            chk("err_count_w2", 96'(err2), ERR_ON ? 96'(err_m2) : 96'd0);
            if (prev_stall && prev_epoch == rst_epoch) begin
                chk("stall_hold", ind_v, prev_v);
            end
            prev_stall = ind_ena && !ind_rdy;
            prev_v     = ind_v;
            prev_epoch = rst_epoch;
            if (streaming && int'(occ) > max_occ) max_occ = int'(occ);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one message and hold it until accepted (bounded).
    task automatic send_msg(input logic [31:0] tag, input logic [31:0] meth, input logic [31:0] v);
        bit ok = 1'b0;
        req_ena = 1'b1;
        req_v   = {tag, meth, v};
        for (int i = 0; i < 50; i++) begin
            if (req_rdy) begin
                step();
                ok = 1'b1;
                break;
            end
            step();
        end
        req_ena = 1'b0;
        if (!ok) chk("accept_timeout", 96'd0, 96'd1);
    endtask

    initial begin
        rst     = 1'b1;
        req_ena = 1'b0;
        req_v   = '0;
        ind_rdy = 1'b1;
        #1;
        chk("rst_ena", 96'(ind_ena), 96'd0);
        chk("rst_v", ind_v, 96'd0);
        chk("rst_occ", 96'(occ), 96'd0);
        chk("rst_err", 96'(err), 96'd0);
        #12 rst = 1'b0;
        step();
        chk("rdy_after_rst", 96'(req_rdy), 96'd1);

        // single say
        send_msg(32'd0, 32'd5, 32'h1234);
        chk("single_ena", 96'(ind_ena), 96'd1);
        chk("single_v", ind_v, 96'h0000_0000_0000_0005_0000_1234);
        chk("single_occ1", 96'(occ), 96'd1);
        step();
        chk("single_occ0", 96'(occ), 96'd0);
        chk("single_ena0", 96'(ind_ena), 96'd0);

        // bad tags
        send_msg(32'd7, 32'd1, 32'd2);
        step();
        chk("bad_no_ind", 96'(ind_ena), 96'd0);
        chk("bad_err1", 96'(err), ERR_ON ? 96'd1 : 96'd0);
        for (int i = 0; i < 4; i++) send_msg(32'd7 + 32'(i), 32'd0, 32'd0);
        step();
        chk("bad_err5", 96'(err), ERR_ON ? 96'd5 : 96'd0);
        chk("bad_err_sat", 96'(err2), ERR_ON ? 96'd3 : 96'd0);

        // backpressure fill
        ind_rdy = 1'b0;
        for (int i = 1; i <= 5; i++) send_msg(32'd0, 32'd0, 32'(i));
        chk("fill_rdy0", 96'(req_rdy), 96'd0);
        chk("fill_occ5", 96'(occ), 96'd5);
        chk("fill_head", ind_v, 96'd1);
        ind_rdy = 1'b1;
        send_msg(32'd0, 32'd0, 32'd6);
        for (int i = 0; i < 8; i++) step();
        chk("fill_drained", 96'(occ), 96'd0);

        // streaming
        streaming = 1'b1;
        max_occ   = 0;
        req_ena   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            req_v = {32'd0, 32'd9, 32'(i + 100)};
            step();
        end
        req_ena = 1'b0;
        step();
        step();
        streaming = 1'b0;
        chk("stream_max_occ", 96'(max_occ <= 1), 96'd1);

        // reset mid-operation
        ind_rdy = 1'b0;
        for (int i = 0; i < 3; i++) send_msg(32'd0, 32'd3, 32'(i + 50));
        chk("pre_rst_occ", 96'(occ), 96'd3);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_ena", 96'(ind_ena), 96'd0);
        chk("async_rst_occ", 96'(occ), 96'd0);
        #1 rst = 1'b0;
        step();
        step();
        chk("post_rst_idle", 96'(ind_ena), 96'd0);
        ind_rdy = 1'b1;
        send_msg(32'd0, 32'd0, 32'hAA);
        chk("post_rst_first", ind_v, 96'hAA);
        step();

        // randomized traffic
        for (int c = 0; c < 10000; c++) begin
            req_ena = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
                req_v = {32'($urandom_range(1, 255)), 32'($urandom), 32'($urandom)};
            end else begin
                req_v = {32'd0, 32'($urandom), 32'($urandom)};
            end
            ind_rdy = ($urandom_range(0, 2) != 0);
            step();
        end
        req_ena = 1'b0;
        ind_rdy = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("final_empty", 96'(occ), 96'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/echo_request_responder.md
# echo_request_responder

Far-end counterpart of the echo connector: accepts packed request messages from the transport, decodes the say method, buffers payloads, and returns each one as a packed heard indication message. It sits between the request-input transport port and the indication-output transport port, so the initiator sees every say(meth, v) echoed back as heard(meth, v), in order.

## Interface
- DEPTH, 4: payload buffer entries; power of two, 2..16.
- ERR_W, 8: width of the dropped-message counter.
- CLK  in  1  clock; all state on rising edge.
- nRST  in  1  reset, asynchronous, active-high (1 = in reset).
- req$enq__ENA  in  1  request message valid; counts only when req$enq__RDY is 1.
- req$enq_v  in  96  [95:64] method tag, [63:32] meth, [31:0] v.
- req$enq__RDY  out  1  buffer can accept a message.
- ind$enq__ENA  out  1  indication message valid.
- ind$enq_v  out  96  [95:64] tag HEARD, [63:32] meth, [31:0] v.
- ind$enq__RDY  in  1  transport takes the message this cycle.
- occupancy  out  $clog2(DEPTH)+1  payloads held, including the output register.
- err_count  out  ERR_W  dropped-message count, saturating.

## Operation
- Accept: req$enq__ENA && req$enq__RDY. req$enq__RDY = !full, independent of the tag value.
- Tag SAY (32'd0): push {meth, v} into buffer.
- Any other tag: message consumed and discarded; err_count increments, saturating at all-ones.
- Output register holds the head payload. ind$enq__ENA = output-register valid. ind$enq_v = {HEARD (32'd0), meth, v}.
- Send: ind$enq__ENA && ind$enq__RDY. The output register refills from the buffer in the same cycle, or is cleared if the buffer is empty.
- Output register and ind$enq_v hold stable while ind$enq__ENA=1 and ind$enq__RDY=0.
- Order preserved; no payload is duplicated or lost.
- Capacity: DEPTH buffer entries plus 1 output register. full = (occupancy == DEPTH+1).
- Simultaneous accept and send when full: accept is blocked because RDY=0, even though a send frees a slot that cycle; no combinational ready path from ind to req.
- Simultaneous accept and send when not full: occupancy unchanged; pointers wrap modulo DEPTH.
- Empty with output register free: a SAY accepted at cycle N bypasses the buffer and loads the output register directly.

## Timing
- Reset (nRST=1, asynchronous): all of the following are 0 immediately: ind$enq__ENA, ind$enq_v, occupancy, err_count, pointers. req$enq__RDY is 1 from the first cycle after release.
- Reset mid-transfer: buffered payloads are lost. No indication is emitted after release until a new SAY is accepted.
- Latency: SAY accepted at edge N gives ind$enq__ENA=1 after edge N (visible in cycle N+1) when empty.
- Throughput: 1 message per cycle in steady state with ind$enq__RDY=1.
- req$enq__RDY is a function of registered state only.
- err_count updates on the edge after the accept.

## Configuration
- ECHO_RESPONDER_ERRCNT_EN defined: err_count counter present as described.
- ECHO_RESPONDER_ERRCNT_EN undefined:
  - Non-SAY messages are still accepted and dropped.
  - err_count is tied to 0 and no counter register exists.

## Structure
- Package echo_pkg holds:
  - ECHO_MSG_W = 96
  - field offsets TAG_LSB=64, METH_LSB=32, V_LSB=0
  - tag constants ECHO_TAG_SAY = 32'd0, ECHO_TAG_HEARD = 32'd0
  - typedef echo_payload_t {meth[31:0], v[31:0]}
- Sub-module echo_msg_fifo: DEPTH-entry payload FIFO with pointers and count, no bypass.
- Top level contains: tag decode, bypass/output register, error counter, occupancy sum.

## Test plan
- Reset then single SAY: tag 0, meth 5, v 0x1234 accepted at cycle 2 -> ind$enq__ENA in cycle 3, ind$enq_v = {0, 5, 0x1234}; occupancy 1 then 0 after send.
- Backpressure fill: ind$enq__RDY=0, DEPTH=4, offer 6 SAYs v=1..6:
  - 5 accepted, req$enq__RDY=0 at occupancy 5.
  - Release ind$enq__RDY -> v 1..5 emitted in order; 6th accepted once RDY returns.
- Streaming: 100 back-to-back SAYs with ind$enq__RDY=1 -> 100 indications on consecutive cycles, values in order, occupancy never exceeds 1.
- Bad tag: tag 7 accepted -> no indication, err_count 1. With ERR_W=2, 5 bad tags -> err_count 3. With macro undefined -> err_count 0.
- Reset mid-operation: 3 payloads held, nRST pulsed mid-cycle -> ind$enq__ENA=0 asynchronously, occupancy 0; next SAY v=0xAA is the first indication.
- Random ENA/RDY for 10k cycles against a scoreboard: no loss, no duplication, stable ind$enq_v under stall.
